// File: rtl/goldschmidt_prenorm.sv
`default_nettype none
// ============================================================================
//  Module      : goldschmidt_prenorm
//  Description : Iterative operand pre-normalizer for the Goldschmidt divider.
//                Left-normalizes dividend and divisor one bit per cycle into
//                Q2.(WIDTH-2) in [0.5, 1) and reports the exponent correction
//                exp_diff so that quotient = (numerator/denominator)*2^exp_diff.
//  Revision    : 1.0 - initial release
// ============================================================================
module goldschmidt_prenorm #(
    parameter int IN_WIDTH = 24,
    parameter int WIDTH    = 28,
    parameter int EXP_W    = $clog2(IN_WIDTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] dividend,
    input  logic [IN_WIDTH-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    numerator,
    output logic [WIDTH-1:0]    denominator,
    output logic [EXP_W-1:0]    exp_diff,
    output logic                div_by_zero
);

    localparam int              LZ_W   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int              PAD    = WIDTH - 2 - IN_WIDTH;
    localparam logic [LZ_W-1:0] LZ_MAX = LZ_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IN_WIDTH-1:0] n_reg;
    logic [IN_WIDTH-1:0] d_reg;
    logic [LZ_W-1:0]     lz_n;
    logic [LZ_W-1:0]     lz_d;
    logic                n_zero;
    logic                n_done;
    logic                d_zero;
    logic                d_done;
    logic                capture;
    logic                finish;
    logic [WIDTH-1:0]    num_aligned;
    logic [WIDTH-1:0]    den_aligned;
    logic [EXP_W-1:0]    exp_calc;

    // Per-operand completion flags and the aligned result candidates
    always_comb begin
        n_zero      = (n_reg == '0);
        n_done      = n_reg[IN_WIDTH-1] || n_zero;
        d_zero      = (d_reg == '0);
        d_done      = d_reg[IN_WIDTH-1] || d_zero;
        num_aligned = WIDTH'(n_reg) << PAD;
        den_aligned = WIDTH'(d_reg) << PAD;
        // Both counts are non-negative and EXP_W exceeds their width, so the
        // two's-complement difference is the correct signed correction.
        exp_calc    = EXP_W'(lz_d) - EXP_W'(lz_n);
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                capture  = in_valid;
                if (in_valid) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                // A zero divisor skips normalization of both operands.
                finish = d_zero || (n_done && d_done);
                if (finish) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and one-bit-per-cycle normalization shifts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reg <= '0;
            d_reg <= '0;
            lz_n  <= '0;
            lz_d  <= '0;
        end else if (capture) begin
            n_reg <= dividend;
            d_reg <= divisor;
            lz_n  <= '0;
            lz_d  <= '0;
        end else if ((state == NORM) && !finish) begin
            if (!n_done) begin
                n_reg <= n_reg << 1;
                if (lz_n != LZ_MAX) begin
                    lz_n <= lz_n + LZ_W'(1);
                end
            end
            if (!d_done) begin
                d_reg <= d_reg << 1;
                if (lz_d != LZ_MAX) begin
                    lz_d <= lz_d + LZ_W'(1);
                end
            end
        end
    end

    // Result registers, loaded once on entry to HOLD and held afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            numerator   <= '0;
            denominator <= '0;
            exp_diff    <= '0;
            div_by_zero <= 1'b0;
        end else if (finish) begin
            if (d_zero) begin
                numerator   <= '0;
                denominator <= '0;
                exp_diff    <= '0;
                div_by_zero <= 1'b1;
            end else begin
                numerator   <= num_aligned;
                denominator <= den_aligned;
                exp_diff    <= n_zero ? '0 : exp_calc;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_goldschmidt_prenorm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_goldschmidt_prenorm
//  Description : Directed self-checking bench for goldschmidt_prenorm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_goldschmidt_prenorm;

    localparam int IN_WIDTH = 24;
    localparam int WIDTH    = 28;
    localparam int EXP_W    = $clog2(IN_WIDTH) + 1;
    localparam int PAD      = WIDTH - 2 - IN_WIDTH;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] dividend;
    logic [IN_WIDTH-1:0] divisor;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    numerator;
    logic [WIDTH-1:0]    denominator;
    logic [EXP_W-1:0]    exp_diff;
    logic                div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Model expectation for the transaction in flight
    logic [WIDTH-1:0] m_num;
    logic [WIDTH-1:0] m_den;
    int               m_exp;
    logic             m_dz;
    int               m_lat;
    logic             cur_active = 1'b0;

    // Values observed at the end of each run_op
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [EXP_W-1:0] r_exp;
    logic             r_dz;
    int               r_lat;

    always #5 clk = ~clk;

    goldschmidt_prenorm #(
        .IN_WIDTH (IN_WIDTH),
        .WIDTH    (WIDTH),
        .EXP_W    (EXP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .numerator   (numerator),
        .denominator (denominator),
        .exp_diff    (exp_diff),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    // Number of leading zeros of a nonzero value (0 for zero)
    function automatic int lzc(input logic [IN_WIDTH-1:0] v);
        int n = 0;
        if (v == '0) return 0;
        while (!v[IN_WIDTH-1-n]) n++;
        return n;
    endfunction

    // Expected result: mantissa moved so its top one sits at bit WIDTH-3,
    // exponent correction = difference of the normalizing shifts.
    task automatic model(input logic [IN_WIDTH-1:0] a, input logic [IN_WIDTH-1:0] b);
        int lzn = lzc(a);
        int lzd = lzc(b);
        m_dz = (b == '0);
        if (b == '0) begin
            m_num = '0;
            m_den = '0;
            m_exp = 0;
            m_lat = 1;
        end else begin
            m_den = WIDTH'(b) << (lzd + PAD);
            m_num = (a == '0) ? '0 : (WIDTH'(a) << (lzn + PAD));
            m_exp = (a == '0) ? 0 : lzd - lzn;
            m_lat = ((lzn > lzd) ? lzn : lzd) + 1;
        end
    endtask

    // Result checker: every cycle a result is presented it must match the model
    always @(negedge clk) begin
        if (!reset && cur_active && out_valid) begin
            check("hold_numerator",   numerator,          m_num);
            check("hold_denominator", denominator,        m_den);
            check("hold_exp_diff",    $signed(exp_diff),  m_exp);
            check("hold_div_by_zero", div_by_zero,        m_dz);
            check("hold_in_ready",    in_ready,           0);
        end
    end

    task automatic run_op(input string tag, input logic [IN_WIDTH-1:0] a,
                          input logic [IN_WIDTH-1:0] b, input int stall, input bit poke);
        int  cyc  = 0;
        bit  seen = 1'b0;
        model(a, b);
        @(negedge clk);
        check({tag, "_in_ready_idle"}, in_ready, 1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        dividend   = IN_WIDTH'($urandom);
        divisor    = IN_WIDTH'($urandom);
        cur_active = 1'b1;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        r_lat = seen ? cyc : -1;
        check({tag, "_latency"}, r_lat, m_lat);
        r_num = numerator;
        r_den = denominator;
        r_exp = exp_diff;
        r_dz  = div_by_zero;
        if (seen) begin
            for (int i = 0; i < stall; i++) begin
                if (poke && i == 1) begin
                    dividend = 24'h0000AB;
                    divisor  = 24'h000003;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid  = 1'b0;
            check({tag, "_still_valid"}, out_valid, 1);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready  = 1'b0;
            cur_active = 1'b0;
            @(negedge clk);
            check({tag, "_valid_drop"}, out_valid, 0);
            check({tag, "_ready_back"}, in_ready, 1);
            if (poke) begin
                @(negedge clk);
                check({tag, "_no_capture"}, in_ready, 1);
                check({tag, "_no_result"}, out_valid, 0);
            end
        end else begin
            cur_active = 1'b0;
        end
    endtask

    task automatic pin(input string tag, input logic [WIDTH-1:0] num,
                       input logic [WIDTH-1:0] den, input int ex, input logic dz);
        check({tag, "_num_lit"}, r_num, num);
        check({tag, "_den_lit"}, r_den, den);
        check({tag, "_exp_lit"}, $signed(r_exp), ex);
        check({tag, "_dz_lit"},  r_dz, dz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",    in_ready,          1);
        check("rst_out_valid",   out_valid,         0);
        check("rst_numerator",   numerator,         0);
        check("rst_denominator", denominator,       0);
        check("rst_exp_diff",    $signed(exp_diff), 0);
        check("rst_div_by_zero", div_by_zero,       0);
        @(negedge clk);
        reset = 1'b0;

        run_op("one_three", 24'h000001, 24'h000003, 2, 1'b0);
        pin("one_three", 28'h2000000, 28'h3000000, -1, 1'b0);
        check("one_three_lat_lit", r_lat, 24);

        run_op("already_norm", 24'h800000, 24'hFFFFFF, 0, 1'b0);
        pin("already_norm", 28'h2000000, 28'h3FFFFFC, 0, 1'b0);
        check("already_norm_lat_lit", r_lat, 1);

        run_op("div_zero", 24'h123456, 24'h000000, 1, 1'b0);
        pin("div_zero", 28'h0, 28'h0, 0, 1'b1);
        check("div_zero_lat_lit", r_lat, 1);

        run_op("backpressure", 24'h000F00, 24'h400000, 5, 1'b1);
        pin("backpressure", 28'h3C00000, 28'h2000000, -11, 1'b0);

        run_op("both_zero", 24'h000000, 24'h000000, 0, 1'b0);
        pin("both_zero", 28'h0, 28'h0, 0, 1'b1);

        run_op("num_zero", 24'h000000, 24'h000005, 1, 1'b0);
        pin("num_zero", 28'h0, 28'h2800000, 0, 1'b0);
        check("num_zero_lat_lit", r_lat, 22);

        run_op("max_pos", 24'hFFFFFF, 24'h000001, 0, 1'b0);
        pin("max_pos", 28'h3FFFFFC, 28'h2000000, 23, 1'b0);

        run_op("max_neg", 24'h000001, 24'h800000, 0, 1'b0);
        pin("max_neg", 28'h2000000, 28'h2000000, -23, 1'b0);

        // Abort a transaction five cycles into normalization
        @(negedge clk);
        dividend = 24'h000001;
        divisor  = 24'h000001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_out_valid",   out_valid,         0);
        check("abort_in_ready",    in_ready,          1);
        check("abort_numerator",   numerator,         0);
        check("abort_denominator", denominator,       0);
        check("abort_exp_diff",    $signed(exp_diff), 0);
        check("abort_div_by_zero", div_by_zero,       0);
        @(negedge clk);
        reset = 1'b0;

        // 2/4 = 0.5 = (0.5/0.5) * 2^-1
        run_op("post_reset", 24'h000002, 24'h000004, 1, 1'b0);
        pin("post_reset", 28'h2000000, 28'h2000000, -1, 1'b0);
        check("post_reset_lat_lit", r_lat, 23);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
